int_mul_fma_unit: RTL
=====================

Name: int_mul_fma_unit

Overview:
- Sequential responder for the integer-multiply mode of mulAddRecFN.
- Accepts operand pairs over a valid/ready request channel and drives the FMA core with integer mode enabled.
- Returns the low W bits of a*b through a LATENCY-stage elastic pipeline with a valid/ready response channel and tag passthrough.
- Sits between an issuing sequencer (or bench driver) and the shared FMA datapath; turns the combinational int-mul path into a pipelined, back-pressurable unit.

Parameters:
- expWidth, 3, FMA exponent width.
- sigWidth, 3, FMA significand width; operand and result width W = expWidth + sigWidth.
- LATENCY, 2, number of pipeline register stages after the FMA core; minimum 1.
- TAG_W, 4, width of the opaque request tag.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request ready.
- in_a  in  W  unsigned multiplicand.
- in_b  in  W  unsigned multiplier.
- in_tag  in  TAG_W  request tag, returned unchanged.
- out_valid  out  1  response valid.
- out_ready  in  1  response ready.
- out_prod  out  W  (in_a*in_b) mod 2^W.
- out_tag  out  TAG_W  tag of the response.
- idle  out  1  high when no operation is in flight.
- inflight  out  clog2(LATENCY+1)  number of accepted but not yet delivered operations.

Behaviour:
- FMA core instantiation:
  - control = 0, op = 2'b00, integer-mode select = 1.
  - a = in_a, b = in_b, c = 0, roundingMode = 0.
  - Integer result output is used; the FP result and exception flags are left unconnected.
- Pipeline structure:
  - Stages s[0..LATENCY-1], each holding valid bit v[i], prod[i] and tag[i].
  - s[0] captures the core output for in_a/in_b.
  - out_* reflect s[LATENCY-1].
- Advance rules:
  - adv[LATENCY-1] = !v[LATENCY-1] || out_ready.
  - adv[i] = !v[i] || adv[i+1]. A bubble collapses; the pipeline is not globally stalled.
  - in_ready = adv[0]. Combinational from out_ready and the valid bits, with no dependence on in_valid.
  - Stage i loads from stage i-1 (or from the request for i = 0) when adv[i].
  - Loaded valid = upstream valid, or in_valid for s[0].
  - Data registers load only when the incoming valid = 1; otherwise the contents hold.
- Handshakes:
  - Request accepted on in_valid && in_ready.
  - Response consumed on out_valid && out_ready.
  - out_valid, once high, stays high with out_prod/out_tag stable until consumed.
- Timing:
  - Latency from acceptance to first visibility on out_valid is exactly LATENCY cycles when unblocked.
  - Throughput is 1 operation/cycle.
  - Simultaneous accept and consume in the same cycle is legal at full occupancy, because in_ready propagates through adv.
- Capacity: at most LATENCY operations in flight. With out_ready = 0 held, exactly LATENCY requests are accepted, then in_ready = 0.
- inflight counter: +1 on accept, -1 on consume, unchanged when both or neither occur. It never exceeds LATENCY or underflows. idle = (inflight == 0).
- Arithmetic: unsigned; result truncated to W bits, with no overflow flag. Operands 0 or 1 are not special-cased.
- Reset values (applied on any cycle with reset = 1, including mid-operation; in-flight operations are discarded and not delivered):
  - v[*] = 0, prod[*] = 0, tag[*] = 0, inflight = 0.
  - Outputs: out_valid = 0, out_prod = 0, out_tag = 0, idle = 1.
  - in_ready = 1 from the first cycle after reset deasserts.
  - in_ready is forced to 0 while reset is high.
- Ordering: responses are strictly in request order; tags are never reordered.

Decomposition:
- Shared package holds:
  - floatControlWidth and the default control word.
  - op encoding constant MULADD_OP_MUL = 2'b00.
  - W derivation function width_of(expWidth, sigWidth).
- One sub-module: int_mul_pipe_stage. It holds a single elastic stage (valid, prod, tag, adv logic) and is instantiated LATENCY times in a generate loop.
- The FMA core is the existing mulAddRecFN, instantiated once, unmodified.

Test Plan:
- Single op, (3,3), LATENCY=2: in_a=7, in_b=9, out_ready=1 -> out_valid high 2 cycles after accept, out_prod=63, tag echoed.
- Truncation, (3,3): in_a=13, in_b=11 -> out_prod=15 (143 mod 64); then (8,24): a=b=0xFFFFFFFF -> out_prod=0x00000001.
- Backpressure, LATENCY=3, out_ready=0, in_valid held with tags 1..4:
  - Exactly 3 accepts, in_ready=0 on the 4th cycle, inflight=3, out_prod/out_tag stable.
  - Raise out_ready -> tags 1,2,3,4 delivered in order, one per cycle, with the 4th accepted in the same cycle tag 1 drains.
- Bubble collapse, LATENCY=3: accept one op, idle 2 cycles, hold out_ready=0 -> the next 2 requests are still accepted, total inflight=3.
- Mid-operation reset: 2 ops in flight, reset high 1 cycle -> next cycle out_valid=0, inflight=0, idle=1, in_ready=1, and no stale response ever appears.
- Random soak: 1000 random a/b with random in_valid/out_ready -> every out_prod equals (a*b) mod 2^W, in order.

Source files
------------

// File: rtl/int_mul_fma_unit_pkg.sv
// Shared constants and helpers for the integer-multiply FMA responder.
// Control word, op encoding and operand width derivation.
package int_mul_fma_unit_pkg;

  localparam int floatControlWidth = 1;

  localparam logic [floatControlWidth-1:0]
    FLOAT_CONTROL_DEFAULT = '0;

  localparam logic [1:0] MULADD_OP_MUL = 2'b00;

  function automatic int width_of(
    input int exp_w,
    input int sig_w
  );
    return exp_w + sig_w;
  endfunction

endpackage

// File: rtl/int_mul_fma_if.sv
// Request/response bundle between a sequencer and the int-mul unit.
// The unit sits on the slave side; the issuer is the master.
interface int_mul_fma_if #(
  parameter int W     = 6,
  parameter int TAG_W = 4,
  parameter int CNT_W = 2
);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_prod;
  logic [TAG_W-1:0] out_tag;
  logic             idle;
  logic [CNT_W-1:0] inflight;

  modport master (
    output in_valid, in_a, in_b, in_tag,
    output out_ready,
    input  in_ready, out_valid, out_prod,
    input  out_tag, idle, inflight
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag,
    input  out_ready,
    output in_ready, out_valid, out_prod,
    output out_tag, idle, inflight
  );

endinterface

// File: rtl/int_mul_pipe_stage.sv
// One elastic register stage: valid/prod/tag with bubble-collapsing
// advance. Data only loads when the incoming valid is set.
module int_mul_pipe_stage #(
  parameter int W     = 6,
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             up_valid,
  input  logic [W-1:0]     up_prod,
  input  logic [TAG_W-1:0] up_tag,
  input  logic             down_adv,
  output logic             valid,
  output logic             adv,
  output logic [W-1:0]     prod,
  output logic [TAG_W-1:0] tag
);

  assign adv = !valid || down_adv;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      prod  <= '0;
      tag   <= '0;
    end else if (adv) begin
      valid <= up_valid;
      if (up_valid) begin
        prod <= up_prod;
        tag  <= up_tag;
      end
    end
  end

endmodule

// File: rtl/mulAddRecFN.sv
// Shared FMA core. The integer path returns the low W bits of a*b;
// the FP path is a simplified model.
module mulAddRecFN
  import int_mul_fma_unit_pkg::*;
#(
  parameter int expWidth = 3,
  parameter int sigWidth = 3
) (
  input  logic [floatControlWidth-1:0]  control,
  input  logic                          int_mul,
  input  logic [1:0]                    op,
  input  logic [expWidth+sigWidth:0]    a,
  input  logic [expWidth+sigWidth:0]    b,
  input  logic [expWidth+sigWidth:0]    c,
  input  logic [2:0]                    roundingMode,
  output logic [expWidth+sigWidth:0]    out,
  output logic [4:0]                    exceptionFlags,
  output logic [expWidth+sigWidth-1:0]  out_imul
);

  localparam int W = expWidth + sigWidth;

  logic [W:0] addend;

  always_comb begin
    addend         = op[0] ? -c : c;
    out_imul       = a[W-1:0] * b[W-1:0];
    out            = int_mul ? '0 : (a * b + addend);
    exceptionFlags = {roundingMode, op}
                   & {5{|control}};
  end

endmodule

// File: rtl/int_mul_fma_unit.sv
// Pipelined, back-pressurable integer multiply on the shared FMA core.
// Responses return in order with their tags.
module int_mul_fma_unit
  import int_mul_fma_unit_pkg::*;
#(
  parameter int expWidth = 3,
  parameter int sigWidth = 3,
  parameter int LATENCY  = 2,
  parameter int TAG_W    = 4
) (
  input  logic         clock,
  input  logic         reset,
  int_mul_fma_if.slave bus
);

  localparam int W     = width_of(expWidth, sigWidth);
  localparam int CNT_W = $clog2(LATENCY + 1);

  logic [W-1:0]     core_prod;
  logic [W:0]       unused_fp_out;
  logic [4:0]       unused_flags;
  logic             accept;
  logic             consume;
  logic [CNT_W-1:0] cnt;

  mulAddRecFN #(
    .expWidth(expWidth),
    .sigWidth(sigWidth)
  ) u_core (
    .control       (FLOAT_CONTROL_DEFAULT),
    .int_mul       (1'b1),
    .op            (MULADD_OP_MUL),
    .a             ({1'b0, bus.in_a}),
    .b             ({1'b0, bus.in_b}),
    .c             ({(W+1){1'b0}}),
    .roundingMode  (3'b000),
    .out           (unused_fp_out),
    .exceptionFlags(unused_flags),
    .out_imul      (core_prod)
  );

  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    logic             up_valid;
    logic [W-1:0]     up_prod;
    logic [TAG_W-1:0] up_tag;
    logic             down_adv;
    logic             valid;
    logic             adv;
    logic [W-1:0]     prod;
    logic [TAG_W-1:0] tag;

    if (i == 0) begin : g_head
      assign up_valid = bus.in_valid;
      assign up_prod  = core_prod;
      assign up_tag   = bus.in_tag;
    end else begin : g_body
      assign up_valid = g_stage[i-1].valid;
      assign up_prod  = g_stage[i-1].prod;
      assign up_tag   = g_stage[i-1].tag;
    end

    if (i == LATENCY - 1) begin : g_tail
      assign down_adv = bus.out_ready;
    end else begin : g_mid
      assign down_adv = g_stage[i+1].adv;
    end

    int_mul_pipe_stage #(
      .W    (W),
      .TAG_W(TAG_W)
    ) u_stage (
      .clock   (clock),
      .reset   (reset),
      .up_valid(up_valid),
      .up_prod (up_prod),
      .up_tag  (up_tag),
      .down_adv(down_adv),
      .valid   (valid),
      .adv     (adv),
      .prod    (prod),
      .tag     (tag)
    );
  end

  assign bus.in_ready  = g_stage[0].adv && !reset;
  assign bus.out_valid = g_stage[LATENCY-1].valid;
  assign bus.out_prod  = g_stage[LATENCY-1].prod;
  assign bus.out_tag   = g_stage[LATENCY-1].tag;

  assign accept  = bus.in_valid && bus.in_ready;
  assign consume = bus.out_valid && bus.out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      unique case ({accept, consume})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.inflight = cnt;
  assign bus.idle     = (cnt == '0);

endmodule
